// File: rtl/fetch_irq_ctrl.sv
// Fetch stage with a vectored, prioritised interrupt controller and PC-save stack.
// Latency: PC, int_ack, int_level and int_active update on every clk edge; a taken irq is fetched next cycle.
// Backpressure: ldStall and HALT hold the PC; jorb redirects it; an irq or RTI overrides both.
//
// Ports:
//   clk, rst (sync, active-high) | newPC/jorb from execute | ldStall from hazard unit
//   irq[NUM_IRQ] level requests  | imem_rdata/imem_addr combinational instruction memory
//   instr/PC/PCPlus1 to decode   | int_ack (one-hot pulse), int_active, int_level status
//
// Build option: define FETCH_IRQ_NESTING_EN for nested interrupts up to STACK_DEPTH.
// Without it a single PC/level save register is used and no irq is taken while one
// is active.
module fetch_irq_ctrl #(
  parameter int          PC_W        = 16,
  parameter int          INSTR_W     = 16,
  parameter int          NUM_IRQ     = 4,
  parameter int          STACK_DEPTH = 4,
  parameter int unsigned RESET_PC    = 0,
  parameter int unsigned VEC_BASE    = 32'h0005,
  parameter int unsigned VEC_STRIDE  = 4,
  localparam int         LVL_W       = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PC_W-1:0]    newPC,
  input  logic               jorb,
  input  logic               ldStall,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [PC_W-1:0]    imem_addr,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    PC,
  output logic [PC_W-1:0]    PCPlus1,
  output logic [NUM_IRQ-1:0] int_ack,
  output logic               int_active,
  output logic [LVL_W-1:0]   int_level
);

`ifdef FETCH_IRQ_NESTING_EN
  localparam int EFF_DEPTH = STACK_DEPTH;
`else
  // Single save slot; STACK_DEPTH has no effect in this build.
  localparam int EFF_DEPTH = (STACK_DEPTH > 0) ? 1 : 1;
`endif
  localparam int DEPTH_W = $clog2(EFF_DEPTH + 1);

  localparam logic [3:0] OP_HALT = 4'h0;
  localparam logic [3:0] OP_RTI  = 4'h3;

  // State
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [NUM_IRQ-1:0] pend_q, pend_d;
  logic [NUM_IRQ-1:0] ack_q, ack_d;
  logic [LVL_W-1:0]   lvl_q, lvl_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic [PC_W-1:0]    stk_pc_q  [EFF_DEPTH];
  logic [PC_W-1:0]    stk_pc_d  [EFF_DEPTH];
  logic [LVL_W-1:0]   stk_lvl_q [EFF_DEPTH];
  logic [LVL_W-1:0]   stk_lvl_d [EFF_DEPTH];

  // Decode / selection
  logic [3:0]         opcode;
  logic               is_halt;
  logic               is_rti;
  logic               rti_pop;
  logic               room;
  logic [PC_W-1:0]    pc_plus1;
  logic [PC_W-1:0]    seq_pc;
  logic [NUM_IRQ-1:0] pend_eff;
  logic [NUM_IRQ-1:0] cand;
  logic               take_vld;
  logic [LVL_W-1:0]   take_idx;
  logic [PC_W-1:0]    vec_pc;
  logic [PC_W-1:0]    top_pc;
  logic [LVL_W-1:0]   top_lvl;

  always_comb begin
    opcode   = imem_rdata[INSTR_W-1 -: 4];
    is_halt  = (opcode == OP_HALT);
    is_rti   = (opcode == OP_RTI);
    rti_pop  = is_rti && (depth_q != '0);
    room     = (int'(depth_q) < EFF_DEPTH);
    pc_plus1 = pc_q + PC_W'(1);

    // Sequential PC is also what gets saved on an irq, so a branch or a stall
    // in the interrupted cycle is honoured on return.
    if (jorb)                    seq_pc = newPC;
    else if (is_halt || ldStall) seq_pc = pc_q;
    else                         seq_pc = pc_plus1;

    // A request is visible in the same cycle it is raised.
    pend_eff = pend_q | irq;

    // Idle: anything goes. Nested: strictly higher priority and a free slot.
    cand = '0;
    for (int k = 0; k < NUM_IRQ; k++) begin
      cand[k] = pend_eff[k] &&
                ((depth_q == '0) || (room && (k < int'(lvl_q))));
    end

    take_vld = 1'b0;
    take_idx = '0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      if (cand[k]) begin
        take_vld = 1'b1;
        take_idx = LVL_W'(k);
      end
    end

    vec_pc = PC_W'(VEC_BASE + 32'(take_idx) * VEC_STRIDE);

    top_pc  = '0;
    top_lvl = '0;
    for (int k = 0; k < EFF_DEPTH; k++) begin
      if (k == int'(depth_q) - 1) begin
        top_pc  = stk_pc_q[k];
        top_lvl = stk_lvl_q[k];
      end
    end
  end

  always_comb begin
    pc_d      = seq_pc;
    pend_d    = pend_eff;
    ack_d     = '0;
    lvl_d     = lvl_q;
    depth_d   = depth_q;
    stk_pc_d  = stk_pc_q;
    stk_lvl_d = stk_lvl_q;

    // RTI beats a simultaneous irq; the irq stays pending for next cycle.
    if (rti_pop) begin
      pc_d    = top_pc;
      depth_d = depth_q - DEPTH_W'(1);
      lvl_d   = (depth_q == DEPTH_W'(1)) ? '0 : top_lvl;
    end else if (take_vld) begin
      for (int k = 0; k < EFF_DEPTH; k++) begin
        if (k == int'(depth_q)) begin
          stk_pc_d[k]  = seq_pc;
          stk_lvl_d[k] = lvl_q;
        end
      end
      depth_d = depth_q + DEPTH_W'(1);
      pc_d    = vec_pc;
      lvl_d   = take_idx;
      ack_d   = NUM_IRQ'(1) << take_idx;
      pend_d  = pend_eff & ~(NUM_IRQ'(1) << take_idx);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= PC_W'(RESET_PC);
      pend_q  <= '0;
      ack_q   <= '0;
      lvl_q   <= '0;
      depth_q <= '0;
    end else begin
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      ack_q   <= ack_d;
      lvl_q   <= lvl_d;
      depth_q <= depth_d;
    end
  end

  // Save-stack contents are only meaningful below depth_q, so no reset needed.
  always_ff @(posedge clk) begin
    stk_pc_q  <= stk_pc_d;
    stk_lvl_q <= stk_lvl_d;
  end

  assign imem_addr  = pc_q;
  assign instr      = imem_rdata;
  assign PC         = pc_q;
  assign PCPlus1    = pc_plus1;
  assign int_ack    = ack_q;
  assign int_active = (depth_q != '0);
  assign int_level  = lvl_q;

endmodule

// File: tb/tb_fetch_irq_ctrl.sv
// Bench for fetch_irq_ctrl: vector table, hand sequences, then random stimulus
// against a queue-based reference model. Honours FETCH_IRQ_NESTING_EN.
module tb_fetch_irq_ctrl;
  localparam int SD = 2;
`ifdef FETCH_IRQ_NESTING_EN
  localparam int M_DEPTH = SD;
  localparam bit M_NEST  = 1'b1;
`else
  localparam int M_DEPTH = 1;
  localparam bit M_NEST  = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, jorb, ldStall;
  logic [15:0] newPC;
  logic [3:0]  irq;
  logic [15:0] imem_rdata, imem_addr, instr, PC, PCPlus1;
  logic [3:0]  int_ack;
  logic        int_active;
  logic [1:0]  int_level;

  logic [15:0] mem [256];
  assign imem_rdata = mem[imem_addr[7:0]];

  always #5 clk = ~clk;

  fetch_irq_ctrl #(.STACK_DEPTH(SD)) dut (
    .clk(clk), .rst(rst), .newPC(newPC), .jorb(jorb), .ldStall(ldStall),
    .irq(irq), .imem_rdata(imem_rdata), .imem_addr(imem_addr), .instr(instr),
    .PC(PC), .PCPlus1(PCPlus1), .int_ack(int_ack), .int_active(int_active),
    .int_level(int_level)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: each frame records where to return and which irq runs.
  typedef struct { logic [15:0] ret_pc; int irq_idx; } frame_t;
  frame_t      m_stack[$];
  logic [15:0] m_pc;
  logic [3:0]  m_pend, m_ack;

  function automatic int m_level();
    return (m_stack.size() == 0) ? 0 : m_stack[$].irq_idx;
  endfunction

  task automatic model_step();
    logic [3:0]  op;
    logic [15:0] seq;
    logic [3:0]  pend;
    int          pick;
    if (rst) begin
      m_pc = 16'h0000; m_pend = '0; m_ack = '0; m_stack.delete();
      return;
    end
    op   = mem[m_pc[7:0]][15:12];
    seq  = jorb ? newPC : ((op == 4'h0 || ldStall) ? m_pc : m_pc + 16'd1);
    pend = m_pend | irq;
    pick = -1;
    for (int i = 0; i < 4; i++)
      if (pick < 0 && pend[i] &&
          (m_stack.size() == 0 ||
           (M_NEST && i < m_level() && m_stack.size() < M_DEPTH)))
        pick = i;
    m_ack = '0;
    if (op == 4'h3 && m_stack.size() > 0) begin
      m_pc = m_stack[$].ret_pc;
      void'(m_stack.pop_back());
    end else if (pick >= 0) begin
      m_stack.push_back('{seq, pick});
      m_pc = 16'(5 + pick * 4);
      m_ack[pick] = 1'b1;
      pend[pick] = 1'b0;
    end else begin
      m_pc = seq;
    end
    m_pend = pend;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] p, input logic [3:0] a,
                       input logic [1:0] l, input logic act);
    logic [15:0] p1;
    p1 = p + 16'd1;
    tests++;
    if (PC !== p || int_ack !== a || int_level !== l || int_active !== act ||
        PCPlus1 !== p1 || imem_addr !== p || instr !== mem[p[7:0]]) begin
      fails++;
      $display("FAIL %s: got PC=%h PCPlus1=%h ack=%b lvl=%0d act=%b, want PC=%h PCPlus1=%h ack=%b lvl=%0d act=%b",
               name, PC, PCPlus1, int_ack, int_level, int_active, p, p1, a, l, act);
    end
  endtask

  task automatic step(input string name, input logic r, input logic j, input logic s,
                      input logic [15:0] n, input logic [3:0] q,
                      input logic [15:0] p, input logic [3:0] a,
                      input logic [1:0] l, input logic act);
    rst = r; jorb = j; ldStall = s; newPC = n; irq = q;
    tick();
    check(name, p, a, l, act);
  endtask

  typedef struct {
    logic r, j, s; logic [15:0] n; logic [3:0] q;
    logic [15:0] p; logic [3:0] a; logic [1:0] l; logic act;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input logic r, input logic j, input logic s,
                              input logic [15:0] n, input logic [3:0] q,
                              input logic [15:0] p, input logic [3:0] a,
                              input logic [1:0] l, input logic act);
    tbl.push_back('{r, j, s, n, q, p, a, l, act});
  endfunction

  initial begin
    rst = 1'b1; jorb = 1'b0; ldStall = 1'b0; newPC = '0; irq = '0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000;
    mem[8'h0D] = 16'h3000;   // RTI
    mem[8'h30] = 16'h0000;   // HALT

    //  rst j  s  newPC     irq       PC        ack       lvl act
    add(1, 0, 0, 16'h0000, 4'b0000, 16'h0000, 4'b0000, 0, 0);
    add(0, 0, 0, 16'h0000, 4'b0000, 16'h0001, 4'b0000, 0, 0);
    add(0, 0, 0, 16'h0000, 4'b0000, 16'h0002, 4'b0000, 0, 0);
    add(0, 0, 0, 16'h0000, 4'b0000, 16'h0003, 4'b0000, 0, 0);
    add(0, 1, 0, 16'h0040, 4'b0000, 16'h0040, 4'b0000, 0, 0);
    add(0, 0, 1, 16'h0000, 4'b0000, 16'h0040, 4'b0000, 0, 0);
    add(0, 0, 1, 16'h0000, 4'b0000, 16'h0040, 4'b0000, 0, 0);
    add(0, 0, 0, 16'h0000, 4'b0000, 16'h0041, 4'b0000, 0, 0);
    add(0, 1, 0, 16'h0008, 4'b0000, 16'h0008, 4'b0000, 0, 0);
    add(0, 0, 0, 16'h0000, 4'b0100, 16'h000D, 4'b0100, 2, 1);
    add(0, 0, 0, 16'h0000, 4'b0000, 16'h0009, 4'b0000, 0, 0);
    add(0, 0, 0, 16'h0000, 4'b0000, 16'h000A, 4'b0000, 0, 0);
    add(0, 1, 0, 16'hFFFF, 4'b0000, 16'hFFFF, 4'b0000, 0, 0);
    add(0, 0, 0, 16'h0000, 4'b0000, 16'h0000, 4'b0000, 0, 0);
    add(0, 1, 0, 16'h0030, 4'b0000, 16'h0030, 4'b0000, 0, 0);
    add(0, 0, 0, 16'h0000, 4'b0000, 16'h0030, 4'b0000, 0, 0);
    add(0, 0, 0, 16'h0000, 4'b0000, 16'h0030, 4'b0000, 0, 0);
    add(0, 0, 0, 16'h0000, 4'b0010, 16'h0009, 4'b0010, 1, 1);
    add(0, 0, 0, 16'h0000, 4'b0000, 16'h000A, 4'b0000, 1, 1);
    add(0, 1, 0, 16'h000D, 4'b0000, 16'h000D, 4'b0000, 1, 1);
    add(0, 0, 0, 16'h0000, 4'b0000, 16'h0030, 4'b0000, 0, 0);
    add(0, 0, 0, 16'h0000, 4'b0000, 16'h0030, 4'b0000, 0, 0);
    add(0, 1, 0, 16'h0020, 4'b0000, 16'h0020, 4'b0000, 0, 0);
    add(0, 0, 1, 16'h0000, 4'b1000, 16'h0011, 4'b1000, 3, 1);
    add(0, 1, 0, 16'h000D, 4'b0000, 16'h000D, 4'b0000, 3, 1);
    add(0, 0, 0, 16'h0000, 4'b0000, 16'h0020, 4'b0000, 0, 0);
    add(0, 1, 0, 16'h000D, 4'b0000, 16'h000D, 4'b0000, 0, 0);
    add(0, 0, 0, 16'h0000, 4'b0000, 16'h000E, 4'b0000, 0, 0);
    add(0, 1, 0, 16'h0050, 4'b0001, 16'h0005, 4'b0001, 0, 1);
    add(0, 1, 0, 16'h000D, 4'b0000, 16'h000D, 4'b0000, 0, 1);
    add(0, 0, 0, 16'h0000, 4'b0000, 16'h0050, 4'b0000, 0, 0);
    add(0, 0, 0, 16'h0000, 4'b0100, 16'h000D, 4'b0100, 2, 1);
    add(0, 0, 0, 16'h0000, 4'b0001, 16'h0051, 4'b0000, 0, 0);
    add(0, 0, 0, 16'h0000, 4'b0000, 16'h0005, 4'b0001, 0, 1);
    add(0, 0, 0, 16'h0000, 4'b0010, 16'h0006, 4'b0000, 0, 1);
    add(1, 0, 0, 16'h0000, 4'b0000, 16'h0000, 4'b0000, 0, 0);
    add(0, 0, 0, 16'h0000, 4'b0000, 16'h0001, 4'b0000, 0, 0);

    for (int k = 0; k < tbl.size(); k++)
      step($sformatf("vec%0d", k), tbl[k].r, tbl[k].j, tbl[k].s, tbl[k].n, tbl[k].q,
           tbl[k].p, tbl[k].a, tbl[k].l, tbl[k].act);

    // Hand sequences: handlers are plain code, return via a jump to an RTI.
    mem[8'h0D] = 16'h1000;
    mem[8'h60] = 16'h3000;
`ifdef FETCH_IRQ_NESTING_EN
    step("nest_rst",   1, 0, 0, 16'h0000, 4'b0000, 16'h0000, 4'b0000, 0, 0);
    step("nest_irq2",  0, 0, 0, 16'h0000, 4'b0100, 16'h000D, 4'b0100, 2, 1);
    step("nest_irq3",  0, 0, 0, 16'h0000, 4'b1000, 16'h000E, 4'b0000, 2, 1);
    step("nest_irq0",  0, 0, 0, 16'h0000, 4'b0001, 16'h0005, 4'b0001, 0, 1);
    step("nest_j1",    0, 1, 0, 16'h0060, 4'b0000, 16'h0060, 4'b0000, 0, 1);
    step("nest_rti1",  0, 0, 0, 16'h0000, 4'b0000, 16'h000F, 4'b0000, 2, 1);
    step("nest_j2",    0, 1, 0, 16'h0060, 4'b0000, 16'h0060, 4'b0000, 2, 1);
    step("nest_rti2",  0, 0, 0, 16'h0000, 4'b0000, 16'h0001, 4'b0000, 0, 0);
    step("nest_take3", 0, 0, 0, 16'h0000, 4'b0000, 16'h0011, 4'b1000, 3, 1);

    step("full_rst",   1, 0, 0, 16'h0000, 4'b0000, 16'h0000, 4'b0000, 0, 0);
    step("full_irq3",  0, 0, 0, 16'h0000, 4'b1000, 16'h0011, 4'b1000, 3, 1);
    step("full_irq2",  0, 0, 0, 16'h0000, 4'b0100, 16'h000D, 4'b0100, 2, 1);
    step("full_irq1",  0, 0, 0, 16'h0000, 4'b0010, 16'h000E, 4'b0000, 2, 1);
    step("full_j",     0, 1, 0, 16'h0060, 4'b0000, 16'h0060, 4'b0000, 2, 1);
    step("full_rti",   0, 0, 0, 16'h0000, 4'b0000, 16'h0012, 4'b0000, 3, 1);
    step("full_take1", 0, 0, 0, 16'h0000, 4'b0000, 16'h0009, 4'b0010, 1, 1);
`else
    step("flat_rst",   1, 0, 0, 16'h0000, 4'b0000, 16'h0000, 4'b0000, 0, 0);
    step("flat_irq3",  0, 0, 0, 16'h0000, 4'b1000, 16'h0011, 4'b1000, 3, 1);
    step("flat_irq0",  0, 0, 0, 16'h0000, 4'b0001, 16'h0012, 4'b0000, 3, 1);
    step("flat_j",     0, 1, 0, 16'h0060, 4'b0000, 16'h0060, 4'b0000, 3, 1);
    step("flat_rti",   0, 0, 0, 16'h0000, 4'b0000, 16'h0001, 4'b0000, 0, 0);
    step("flat_take0", 0, 0, 0, 16'h0000, 4'b0000, 16'h0005, 4'b0001, 0, 1);
`endif

    // Random phase against the reference model.
    for (int i = 0; i < 256; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 6)       mem[i] = {4'h0, 12'($urandom)};
      else if (r < 20) mem[i] = {4'h3, 12'($urandom)};
      else             mem[i] = 16'($urandom);
    end
    rst = 1'b1; jorb = 1'b0; ldStall = 1'b0; irq = '0;
    tick();
    check("rand_rst", m_pc, m_ack, 2'(m_level()), m_stack.size() != 0);
    for (int c = 0; c < 3000; c++) begin
      rst     = ($urandom_range(0, 299) == 0);
      jorb    = ($urandom_range(0, 7) == 0);
      newPC   = ($urandom_range(0, 1) == 0) ? 16'($urandom) : {8'h00, 8'($urandom)};
      ldStall = ($urandom_range(0, 5) == 0);
      for (int b = 0; b < 4; b++) irq[b] = ($urandom_range(0, 9) == 0);
      tick();
      check($sformatf("rand%0d", c), m_pc, m_ack, 2'(m_level()), m_stack.size() != 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fetch_irq_ctrl.md
Name: fetch_irq_ctrl

Overview:
- Parametrised fetch stage: PC register, next-PC selection, instruction-memory address drive.
- Adds a multi-source vectored interrupt controller with a hardware PC-save stack for prioritised nested interrupts.
- Sits at the front of the pipeline. Feeds instr/PC/PCPlus1 to decode. Takes jorb/newPC from execute and ldStall from the hazard unit.

Parameters:
- PC_W, 16: PC and address width.
- INSTR_W, 16: instruction width; opcode = instr[INSTR_W-1:INSTR_W-4].
- NUM_IRQ, 4: interrupt sources; index 0 = highest priority.
- STACK_DEPTH, 4: save-stack entries, i.e. max nesting depth.
- RESET_PC, 0: PC after reset.
- VEC_BASE, 16'h0005: handler address for irq 0.
- VEC_STRIDE, 4: address spacing between handler vectors.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- newPC  in  PC_W  branch/jump target.
- jorb  in  1  take newPC.
- ldStall  in  1  load-use stall; hold PC.
- irq  in  NUM_IRQ  interrupt requests; level, sampled each cycle.
- imem_rdata  in  INSTR_W  instruction memory read data; combinational read of imem_addr.
- imem_addr  out  PC_W  equals PC.
- instr  out  INSTR_W  equals imem_rdata.
- PC  out  PC_W  current PC.
- PCPlus1  out  PC_W  PC+1, modulo 2^PC_W.
- int_ack  out  NUM_IRQ  registered one-hot pulse, one cycle after an irq is taken.
- int_active  out  1  stack depth != 0.
- int_level  out  clog2(NUM_IRQ)  priority of the running handler; 0 when idle.

Behaviour:
- Reset (synchronous): PC=RESET_PC, pending=0, stack depth=0, int_ack=0, int_active=0, int_level=0.
- Opcodes:
  - HALT = 4'h0: hold PC.
  - RTI = 4'h3: return from interrupt.
- pending[i]:
  - Set while irq[i]=1.
  - Cleared in the cycle irq i is taken, unless irq[i] is still high in the following cycle.
- Eligible irq: lowest index i with pending[i]=1 that is either:
  - with depth=0, or
  - with depth>0 and i < int_level, and depth<STACK_DEPTH.
- seqPC = jorb ? newPC : HALT ? PC : ldStall ? PC : PCPlus1.
- nextPC priority, highest first:
  1. RTI with depth>0: pop; nextPC = popped PC; int_level = popped level, or 0 if stack now empty.
  2. Eligible irq i: push {seqPC, current int_level}; nextPC = VEC_BASE + i*VEC_STRIDE (truncated to PC_W); int_level = i; int_ack[i]=1 next cycle.
  3. Otherwise nextPC = seqPC.
- RTI at depth=0: treated as NOP; PC = seqPC.
- RTI and eligible irq in the same cycle: RTI wins; irq stays pending and is re-evaluated next cycle against the restored int_level.
- Stack full (depth=STACK_DEPTH): no irq is taken; requests remain pending.
- Equal or lower priority than the running handler: held pending until RTI lowers int_level or empties the stack.
- Interrupt during HALT: saved PC is the HALT address; RTI resumes at HALT.
- Interrupt during ldStall: saved PC is the stalled PC.
- Interrupt during jorb: saved PC is newPC, so the branch is not lost.
- int_ack is a pure one-cycle pulse; never more than one bit set.
- Latency:
  - PC updates on every clk edge.
  - Handler's first fetch occurs the cycle after the irq is taken.
  - Returned PC is fetched the cycle after RTI.

Optional Feature:
- Macro FETCH_IRQ_NESTING_EN.
- Defined: nesting as described; effective depth = STACK_DEPTH.
- Undefined:
  - Effective depth = 1.
  - No irq is taken while int_active=1, regardless of priority.
  - Stack storage reduces to a single PC/level register.
  - STACK_DEPTH is ignored.

Test Plan:
- Sequential fetch:
  - rst for 1 cycle, then release → PC=0,1,2,3 on successive cycles; PCPlus1=PC+1.
  - PC at 16'hFFFF → next PC 16'h0000.
- Branch and stall:
  - jorb=1, newPC=16'h0040 at PC=3 → next PC 16'h0040.
  - ldStall=1 for 2 cycles → PC held 2 cycles.
  - instr opcode 0 → PC held indefinitely.
- Single interrupt:
  - irq[2]=1 pulse at PC=8 → next PC=16'h000D; int_ack=4'b0100 one cycle later; int_level=2.
  - Handler at 16'h000D (opcode 3) → PC returns to 9; int_active=0.
- Nesting (FETCH_IRQ_NESTING_EN defined):
  - In irq-2 handler, raise irq[3] → not taken.
  - Raise irq[0] → PC=16'h0005; depth=2.
  - RTI → back in irq-2 handler.
  - Second RTI → irq[3] taken next cycle.
- Boundaries:
  - STACK_DEPTH=2; irq[3], [2], [1] raised in succession → third request held pending until an RTI.
  - RTI and irq[0] in the same cycle → RTI performed first, irq[0] taken next cycle.
  - RTI at depth 0 → PC+1.
  - rst mid-handler → PC=RESET_PC, int_active=0, all pending cleared.
